mux_nx1_rr: RTL
===============

Name: mux_nx1_rr

Overview:
Parametrised N-to-1 multiplexer with a registered output stage and valid/ready handshaking on every input and on the output. It is the successor to the fixed 4:1 mux. It adds configurable data width and channel count, plus two selection modes: fixed (external sel) and round-robin (internal pointer). It sits between multiple producer channels and one consumer, and its output stage is one register deep.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels; legal range 2..16.
- SELW, 2, select width; must equal ceil(log2(N)); the bench checks this.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  channel i has data.
- in_ready  out  N  channel i data accepted this cycle; combinational.
- sel  in  SELW  channel index used in fixed mode.
- mode  in  1  0 = fixed (use sel), 1 = round-robin.
- out  out  WIDTH  registered output data.
- out_valid  out  1  out holds valid data.
- out_ready  in  1  consumer accepts out this cycle.
- out_sel  out  SELW  index of the channel that supplied the current out.

Behaviour:
- Reset (async assert, synchronous release):
  - out = 0, out_valid = 0, out_sel = 0, rr pointer ptr = 0.
  - Any data held at assertion is dropped; no in_ready is asserted while rst is high.
- Output register enable: load_en = !out_valid || out_ready. A held word is replaced in the same cycle it is consumed, so full throughput is 1 word/cycle.
- Grant, fixed mode (mode=0):
  - grant = sel if sel < N and in_valid[sel]=1; otherwise no grant.
  - ptr is held unchanged.
- Grant, round-robin mode (mode=1):
  - grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
  - No grant if in_valid is all zeros.
- Transfer (when load_en and a grant exist):
  - in_ready[grant] = 1; all other in_ready bits = 0.
  - On the clock edge: out <= in_data[grant], out_sel <= grant, out_valid <= 1.
  - In mode 1 only: ptr <= (grant+1) mod N.
- load_en with no grant: out_valid <= 0 at the edge; out and out_sel hold their last values.
- !load_en (out_valid=1, out_ready=0), i.e. stall:
  - All in_ready = 0.
  - out, out_sel and out_valid are held stable.
  - Inputs may change freely; the held data must not change.
- Latency: a word accepted at edge k appears on out with out_valid=1 immediately after edge k, i.e. a 1-cycle input-to-output register.
- Simultaneous accept and consume: allowed. out_valid stays 1 and the new word replaces the old one.
- Mode switching:
  - A change of mode takes effect on the same cycle's grant calculation; there is no pipeline bubble.
  - ptr is preserved across mode switches.
- Fairness: in mode 1 with all channels continuously valid and out_ready=1, the grant sequence is 0,1,...,N-1,0,... Each channel waits at most N-1 grants.
- Out-of-range sel (N not a power of 2, sel >= N): no grant, no in_ready asserted, no X propagation.
- Combinational paths: in_ready depends combinationally on in_valid, sel, mode, ptr, out_valid and out_ready. out has no combinational path from any input.

Test Plan:
1. Reset check. Hold rst=1 with random inputs for 3 cycles, then assert rst asynchronously mid-cycle while out_valid=1.
   -> out=0, out_valid=0, out_sel=0 immediately, and in_ready=0 while rst is high.
2. Fixed-mode selection. Set WIDTH=8, N=4, mode=0, in_data={d:8'hDD, c:8'hCC, b:8'hBB, a:8'hAA}, all valid, out_ready=1; step sel 0,1,2,3.
   -> One cycle later, out = AA, BB, CC, DD and out_sel = 0,1,2,3. Exactly one in_ready bit is high, matching sel.
3. Round-robin rotation. Set mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles.
   -> out_sel sequence is 0,1,2,3,0,1,2,3. Then set in_valid=4'b0101 with ptr=1.
   -> Grants are 2,0,2,0.
4. Backpressure. Set mode=1, all valid; hold out_ready=0 for 4 cycles after the first accept.
   -> out and out_sel are held; in_ready=0 throughout; ptr is unchanged. Release out_ready.
   -> The next grant is (held out_sel+1) mod 4, and there is no dropped or duplicated word.
5. Idle and invalid. Set mode=0 with sel=2 and in_valid[2]=0, out_ready=1.
   -> out_valid goes to 0 after one edge; in_ready=0; out holds its previous value.
6. Mode switch mid-stream. Run mode=1 until ptr=3, switch to mode=0 with sel=1 for 2 words, then return to mode=1.
   -> The fixed-mode words come from channel 1, and the next round-robin grant starts scanning at channel 3.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// N-to-1 valid/ready multiplexer with a one-deep registered output stage.
// Channel choice is either an external select (mode 0) or a round-robin pointer (mode 1).
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    logic [SELW-1:0]  ptr;
    logic             load_en;
    logic             fx_hit;
    logic             rr_hit;
    logic [SELW-1:0]  rr_idx;
    logic             hit_p0;
    logic [SELW-1:0]  grant_p0;
    logic [SELW-1:0]  ptr_nxt;
    logic [WIDTH-1:0] data_p0;

    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return SELW'(s);
    endfunction

    assign load_en = !out_valid || out_ready;

    // Fixed select: an out-of-range sel never indexes in_valid, so no X can leak into a grant.
    always_comb begin
        fx_hit = 1'b0;
        if (int'(sel) < N) begin
            fx_hit = in_valid[sel];
        end
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (in_valid[wrap_add(ptr, k)]) begin
                rr_hit = 1'b1;
                rr_idx = wrap_add(ptr, k);
            end
        end
    end

    assign hit_p0   = mode ? rr_hit : fx_hit;
    assign grant_p0 = mode ? rr_idx : sel;
    assign ptr_nxt  = wrap_add(grant_p0, 1);

    always_comb begin
        data_p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(grant_p0) == i) begin
                data_p0 = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && load_en && hit_p0) begin
            in_ready[grant_p0] = 1'b1;
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (hit_p0) begin
                out       <= data_p0;
                out_sel   <= grant_p0;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
